fv_rd_req_router: RTL and testbench
===================================

Name: fv_rd_req_router

Overview:
- Sits directly upstream of the big feature-vector (FV) memory wrapper.
- Collects FV read requests from the edge PEs and steers each request to its bank (low-order interleave).
- Arbitrates round-robin when several PEs hit the same bank in one cycle.
- Buffers per bank in a small FIFO and presents one request per bank per cycle, with its PE tag, to the bank controllers.

Parameters:
- NUM_PE, 4, number of requesting edge PEs
- NUM_BANKS, 4, number of FV banks; power of 2, >=2
- FV_IDX_W, 8, width of the global FV index
- FIFO_DEPTH, 4, entries per bank FIFO; power of 2
- BANK_W, $clog2(NUM_BANKS), bank-select width (derived)
- TAG_W, $clog2(NUM_PE), PE tag width (derived)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- flush  in  1  synchronous clear of all FIFOs and arbiters
- pe_req_valid  in  NUM_PE  per-PE request valid
- pe_req_idx  in  NUM_PE*FV_IDX_W  per-PE global FV index
- pe_req_ready  out  NUM_PE  request accepted this cycle
- bank_req_valid  out  NUM_BANKS  FIFO head valid toward bank controller
- bank_req_addr  out  NUM_BANKS*(FV_IDX_W-BANK_W)  bank-local line address
- bank_req_tag  out  NUM_BANKS*TAG_W  originating PE id
- bank_req_ready  in  NUM_BANKS  bank controller consumes head this cycle
- fifo_full  out  NUM_BANKS  per-bank FIFO full flag

Behaviour:
- Address split:
  - bank = pe_req_idx[BANK_W-1:0]
  - bank_req_addr = pe_req_idx >> BANK_W
  - Pure bit slicing; no arithmetic.
- Arbitration, per bank, combinational:
  - Candidates are the PEs with valid=1 whose bank matches.
  - Grant the first candidate at or after rr_ptr[bank], scanning upward with wrap NUM_PE-1 -> 0.
  - At most one grant per bank per cycle.
  - A PE targets exactly one bank, so it sees at most one grant.
- pe_req_ready[p] = granted, and the target FIFO is not full (count < FIFO_DEPTH), and flush = 0.
  - No combinational path from bank_req_ready to pe_req_ready; push into a full FIFO is refused even when a pop occurs in the same cycle.
- Handshake:
  - A request is transferred when valid & ready.
  - An ungranted PE must hold valid and idx stable. Holding is required of the PE, not checked.
- Round-robin pointer update: on a push into bank b from PE p, rr_ptr[b] <= (p+1) mod NUM_PE. No push leaves the pointer unchanged.
- FIFO behaviour:
  - Push is registered. An entry accepted in cycle N appears at bank_req_valid in cycle N+1 if the FIFO was empty. Minimum latency is 1 cycle.
  - Pop happens when bank_req_valid & bank_req_ready.
  - Simultaneous push and pop: count is unchanged, order is preserved.
  - Pointers wrap modulo FIFO_DEPTH; count is FIFO_DEPTH+1 states wide.
  - bank_req_addr and bank_req_tag show the head entry and are held stable while valid & !ready.
- fifo_full[b] = (count[b] == FIFO_DEPTH), registered-derived.
- flush:
  - Next cycle, all counts, read/write pointers and rr_ptr are 0.
  - Requests presented during the flush cycle are not accepted (ready=0).
  - A pop during flush is discarded.
- Reset (reset==0 at a clk edge), including mid-operation:
  - Same clearing as flush.
  - While in reset: bank_req_valid=0, pe_req_ready=0, fifo_full=0.
  - Payload outputs are don't-care while valid=0 but are driven 0 after reset.
- The router does no reordering within a bank.
  - Requests from one PE to different banks may complete out of order; the consumer matches responses by tag.

Optional Feature:
- Macro: FV_RD_REQ_ROUTER_STATS_EN
- Enabled:
  - Adds output conflict_cnt, NUM_BANKS*16 bits.
  - Per bank, counts the cycles where ≥2 PEs requested the bank, or a valid request was refused because the FIFO was full.
  - Saturates at 16'hFFFF; cleared by reset and by flush.
- Disabled: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Single request: PE0 idx=8'h25, all banks ready -> pe_req_ready[0]=1 that cycle; next cycle bank_req_valid[1]=1, addr=6'h09, tag=0.
- Bank conflict: PE0..PE3 all idx with bank 2 in the same cycle, rr_ptr=0, bank never ready:
  - Grants occur PE0, PE1, PE2, PE3 on consecutive cycles.
  - After the 4th push fifo_full[2]=1 and no further grant.
- Fairness wrap: after the last grant to PE3 on bank 0, PE0 and PE3 request bank 0 -> PE0 is granted first (rr_ptr=0), then PE3.
- Full with simultaneous pop: bank 1 full, bank_req_ready[1]=1, PE2 requests bank 1:
  - pe_req_ready[2]=0 that cycle and count drops to 3.
  - The next cycle PE2 is accepted.
- Flush mid-stream: FIFOs 0 and 3 holding 2 entries each, flush=1 for one cycle -> next cycle all bank_req_valid=0, fifo_full=0; requests in the flush cycle are not accepted.
- Reset mid-operation: reset=0 while 3 entries are queued -> next cycle all outputs are 0. After release, a new PE1 idx=8'h03 request is routed to bank 3, addr 0, tag 1, with 1-cycle latency.

Source files
------------

// File: rtl/fv_rd_req_router.sv
// FV read-request router: steers PE reads to low-order interleaved banks
// with per-bank round-robin arbitration and a small per-bank request FIFO.
// Optional per-bank conflict counters: define FV_RD_REQ_ROUTER_STATS_EN.
module fv_rd_req_router #(
   parameter int NUM_PE     = 4,
   parameter int NUM_BANKS  = 4,
   parameter int FV_IDX_W   = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int BANK_W     = $clog2(NUM_BANKS),
   parameter int TAG_W      = $clog2(NUM_PE)
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   flush,
   input  logic [NUM_PE-1:0]                      pe_req_valid,
   input  logic [NUM_PE*FV_IDX_W-1:0]             pe_req_idx,
   output logic [NUM_PE-1:0]                      pe_req_ready,
   output logic [NUM_BANKS-1:0]                   bank_req_valid,
   output logic [NUM_BANKS*(FV_IDX_W-BANK_W)-1:0] bank_req_addr,
   output logic [NUM_BANKS*TAG_W-1:0]             bank_req_tag,
   input  logic [NUM_BANKS-1:0]                   bank_req_ready,
`ifdef FV_RD_REQ_ROUTER_STATS_EN
   output logic [NUM_BANKS*16-1:0]                conflict_cnt,
`endif
   output logic [NUM_BANKS-1:0]                   fifo_full
);

   localparam int ADDR_W = FV_IDX_W - BANK_W;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

   logic [BANK_W-1:0] pe_bank   [NUM_PE];
   logic [ADDR_W-1:0] pe_addr   [NUM_PE];

   logic [TAG_W-1:0]  rr_ptr    [NUM_BANKS];
   logic [CNT_W-1:0]  count     [NUM_BANKS];
   logic [PTR_W-1:0]  wr_ptr    [NUM_BANKS];
   logic [PTR_W-1:0]  rd_ptr    [NUM_BANKS];
   logic [ADDR_W-1:0] mem_addr  [NUM_BANKS][FIFO_DEPTH];
   logic [TAG_W-1:0]  mem_tag   [NUM_BANKS][FIFO_DEPTH];

   logic [NUM_PE-1:0]    req_hit  [NUM_BANKS];
   logic [NUM_PE-1:0]    grant;
   logic [NUM_BANKS-1:0] found;
   logic [NUM_BANKS-1:0] push;
   logic [NUM_BANKS-1:0] pop;
   logic [NUM_BANKS-1:0] full;
   logic [TAG_W-1:0]     push_tag  [NUM_BANKS];
   logic [ADDR_W-1:0]    push_addr [NUM_BANKS];

   // Split each PE index into bank select (low bits) and bank-local line.
   always_comb begin
      for (int p = 0; p < NUM_PE; p++) begin
         pe_bank[p] = pe_req_idx[p*FV_IDX_W +: BANK_W];
         pe_addr[p] = pe_req_idx[p*FV_IDX_W+BANK_W +: ADDR_W];
      end
   end

   // Per-bank round-robin pick: first requester at or after rr_ptr.
   always_comb begin
      logic [TAG_W-1:0] sel;
      grant = '0;
      found = '0;
      sel   = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         push_tag[b]  = '0;
         push_addr[b] = '0;
         req_hit[b]   = '0;
         for (int p = 0; p < NUM_PE; p++) begin
            req_hit[b][p] = pe_req_valid[p] &&
                            (pe_bank[p] == BANK_W'(b));
         end
         for (int k = 0; k < NUM_PE; k++) begin
            sel = TAG_W'((int'(rr_ptr[b]) + k) % NUM_PE);
            if (!found[b] && req_hit[b][sel]) begin
               found[b]     = 1'b1;
               grant[sel]   = 1'b1;
               push_tag[b]  = sel;
               push_addr[b] = pe_addr[sel];
            end
         end
      end
   end

   // Handshake: ready only from registered fullness, never from bank ready.
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         full[b] = (count[b] == CNT_W'(FIFO_DEPTH));
         bank_req_valid[b] = (count[b] != '0);
         push[b] = found[b] && !full[b] && !flush && reset;
         pop[b]  = bank_req_valid[b] && bank_req_ready[b] && !flush;
      end
      for (int p = 0; p < NUM_PE; p++) begin
         pe_req_ready[p] = grant[p] && !full[pe_bank[p]] &&
                           !flush && reset;
      end
   end

   assign fifo_full = full;

   // Head entry toward each bank controller, zeroed while empty.
   always_comb begin
      bank_req_addr = '0;
      bank_req_tag  = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (bank_req_valid[b]) begin
            bank_req_addr[b*ADDR_W +: ADDR_W] = mem_addr[b][rd_ptr[b]];
            bank_req_tag[b*TAG_W +: TAG_W]    = mem_tag[b][rd_ptr[b]];
         end
      end
   end

   // FIFO occupancy, pointers and arbitration pointers.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (!reset || flush) begin
            count[b]  <= '0;
            wr_ptr[b] <= '0;
            rd_ptr[b] <= '0;
            rr_ptr[b] <= '0;
         end else begin
            if (push[b]) begin
               wr_ptr[b] <= (wr_ptr[b] == PTR_W'(FIFO_DEPTH - 1)) ?
                            '0 : wr_ptr[b] + 1'b1;
               rr_ptr[b] <= TAG_W'((int'(push_tag[b]) + 1) % NUM_PE);
            end
            if (pop[b]) begin
               rd_ptr[b] <= (rd_ptr[b] == PTR_W'(FIFO_DEPTH - 1)) ?
                            '0 : rd_ptr[b] + 1'b1;
            end
            case ({push[b], pop[b]})
               2'b10:   count[b] <= count[b] + 1'b1;
               2'b01:   count[b] <= count[b] - 1'b1;
               default: count[b] <= count[b];
            endcase
         end
      end
   end

   // FIFO storage; payload needs no reset since outputs gate on valid.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (push[b]) begin
            mem_addr[b][wr_ptr[b]] <= push_addr[b];
            mem_tag[b][wr_ptr[b]]  <= push_tag[b];
         end
      end
   end

`ifdef FV_RD_REQ_ROUTER_STATS_EN
   logic [15:0]          conf_q   [NUM_BANKS];
   logic [NUM_BANKS-1:0] conf_hit;

   // A bank is contended when 2+ PEs want it or a request meets a full FIFO.
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         conf_hit[b] = ($countones(req_hit[b]) >= 2) ||
                       ((|req_hit[b]) && full[b]);
      end
   end

   // Saturating per-bank contention counters.
   always_ff @(posedge clk) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (!reset || flush) begin
            conf_q[b] <= '0;
         end else if (conf_hit[b] && (conf_q[b] != 16'hFFFF)) begin
            conf_q[b] <= conf_q[b] + 16'd1;
         end
      end
   end

   // Flatten the counters onto the output bus.
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         conflict_cnt[b*16 +: 16] = conf_q[b];
      end
   end
`endif

endmodule

// File: tb/tb_fv_rd_req_router.sv
// Testbench for fv_rd_req_router: directed scenarios plus a randomized
// run scored against a queue-based reference model.
module tb_fv_rd_req_router;

   localparam int NP = 4;
   localparam int NB = 4;
   localparam int IW = 8;
   localparam int FD = 4;
   localparam int BW = 2;
   localparam int TW = 2;
   localparam int AW = 6;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic [NP-1:0]    pe_req_valid;
   logic [NP*IW-1:0] pe_req_idx;
   logic [NP-1:0]    pe_req_ready;
   logic [NB-1:0]    bank_req_valid;
   logic [NB*AW-1:0] bank_req_addr;
   logic [NB*TW-1:0] bank_req_tag;
   logic [NB-1:0]    bank_req_ready;
   logic [NB-1:0]    fifo_full;
`ifdef FV_RD_REQ_ROUTER_STATS_EN
   logic [NB*16-1:0] conflict_cnt;
`endif

   int checks = 0;
   int failures = 0;

   bit [7:0] mq [NB][$];
   int       rr [NB];

   always #5 clk = ~clk;

   fv_rd_req_router dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .pe_req_valid(pe_req_valid),
      .pe_req_idx(pe_req_idx),
      .pe_req_ready(pe_req_ready),
      .bank_req_valid(bank_req_valid),
      .bank_req_addr(bank_req_addr),
      .bank_req_tag(bank_req_tag),
      .bank_req_ready(bank_req_ready),
`ifdef FV_RD_REQ_ROUTER_STATS_EN
      .conflict_cnt(conflict_cnt),
`endif
      .fifo_full(fifo_full)
   );

   task automatic idle();
      pe_req_valid   = '0;
      pe_req_idx     = '0;
      bank_req_ready = '0;
      flush          = 1'b0;
   endtask

   task automatic set_req(input int p, input logic [7:0] idx);
      pe_req_valid[p]        = 1'b1;
      pe_req_idx[p*IW +: IW] = idx;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0;
      set_req(0, 8'h25);
      bank_req_ready = '1;
      tick();
      checks++;
      if (bank_req_valid !== 4'b0000) begin
         failures++;
         $display("FAIL reset_valid got=%b exp=0000", bank_req_valid);
      end
      checks++;
      if (fifo_full !== 4'b0000) begin
         failures++;
         $display("FAIL reset_full got=%b exp=0000", fifo_full);
      end
      checks++;
      if (bank_req_addr !== '0 || bank_req_tag !== '0) begin
         failures++;
         $display("FAIL reset_payload addr=%h tag=%h exp=0",
                  bank_req_addr, bank_req_tag);
      end
      @(negedge clk);
      checks++;
      if (pe_req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=0000", pe_req_ready);
      end
      tick();
      idle();
      reset = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      set_req(0, 8'h25);
      bank_req_ready = '1;
      @(negedge clk);
      checks++;
      if (pe_req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL single_ready got=%b exp=0001", pe_req_ready);
      end
      tick();
      idle();
      checks++;
      if (bank_req_valid !== 4'b0010 ||
          bank_req_addr[1*AW +: AW] !== 6'h09 ||
          bank_req_tag[1*TW +: TW] !== 2'd0) begin
         failures++;
         $display("FAIL single_out valid=%b addr=%h tag=%0d exp=0010/09/0",
                  bank_req_valid, bank_req_addr[1*AW +: AW],
                  bank_req_tag[1*TW +: TW]);
      end
      bank_req_ready = '1;
      tick();
      checks++;
      if (bank_req_valid !== 4'b0000) begin
         failures++;
         $display("FAIL single_pop got=%b exp=0000", bank_req_valid);
      end
      idle();
   endtask

   task automatic test_conflict();
      logic [7:0] v;
      do_reset();
      for (int p = 0; p < NP; p++) begin
         v = 8'(p * 4 + 2);
         set_req(p, v);
      end
      for (int k = 0; k < NP; k++) begin
         @(negedge clk);
         checks++;
         if (pe_req_ready !== 4'(1 << k)) begin
            failures++;
            $display("FAIL conflict_grant k=%0d got=%b exp=%b",
                     k, pe_req_ready, 4'(1 << k));
         end
         tick();
         pe_req_valid[k] = 1'b0;
      end
      checks++;
      if (fifo_full !== 4'b0100) begin
         failures++;
         $display("FAIL conflict_full got=%b exp=0100", fifo_full);
      end
      set_req(0, 8'h12);
      @(negedge clk);
      checks++;
      if (pe_req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL conflict_nogrant got=%b exp=0000", pe_req_ready);
      end
      tick();
      idle();
      bank_req_ready = 4'b0100;
      for (int k = 0; k < NP; k++) begin
         checks++;
         if (bank_req_tag[2*TW +: TW] !== TW'(k) ||
             bank_req_addr[2*AW +: AW] !== AW'(k)) begin
            failures++;
            $display("FAIL conflict_order k=%0d tag=%0d addr=%h exp=%0d",
                     k, bank_req_tag[2*TW +: TW],
                     bank_req_addr[2*AW +: AW], k);
         end
         tick();
      end
      checks++;
      if (bank_req_valid !== 4'b0000) begin
         failures++;
         $display("FAIL conflict_drain got=%b exp=0000", bank_req_valid);
      end
      idle();
   endtask

   task automatic test_fairness();
      int et [3];
      int ea [3];
      et = '{3, 0, 3};
      ea = '{4, 1, 2};
      do_reset();
      set_req(3, 8'h10);
      @(negedge clk);
      checks++;
      if (pe_req_ready !== 4'b1000) begin
         failures++;
         $display("FAIL fair_first got=%b exp=1000", pe_req_ready);
      end
      tick();
      set_req(0, 8'h04);
      set_req(3, 8'h08);
      @(negedge clk);
      checks++;
      if (pe_req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL fair_wrap got=%b exp=0001", pe_req_ready);
      end
      tick();
      pe_req_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (pe_req_ready !== 4'b1000) begin
         failures++;
         $display("FAIL fair_next got=%b exp=1000", pe_req_ready);
      end
      tick();
      idle();
      bank_req_ready = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (bank_req_tag[0 +: TW] !== TW'(et[k]) ||
             bank_req_addr[0 +: AW] !== AW'(ea[k])) begin
            failures++;
            $display("FAIL fair_order k=%0d tag=%0d addr=%h exp=%0d/%h",
                     k, bank_req_tag[0 +: TW], bank_req_addr[0 +: AW],
                     et[k], ea[k]);
         end
         tick();
      end
      idle();
   endtask

   task automatic test_full_pop();
      logic [7:0] v;
      int ea [4];
      int et [4];
      ea = '{1, 2, 3, 16};
      et = '{0, 0, 0, 2};
      do_reset();
      for (int k = 0; k < FD; k++) begin
         v = 8'(k * 4 + 1);
         set_req(0, v);
         @(negedge clk);
         checks++;
         if (pe_req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL fullpop_fill k=%0d got=%b exp=0001",
                     k, pe_req_ready);
         end
         tick();
      end
      idle();
      checks++;
      if (fifo_full !== 4'b0010) begin
         failures++;
         $display("FAIL fullpop_full got=%b exp=0010", fifo_full);
      end
      set_req(2, 8'h41);
      bank_req_ready = 4'b0010;
      @(negedge clk);
      checks++;
      if (pe_req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL fullpop_refuse got=%b exp=0000", pe_req_ready);
      end
      tick();
      bank_req_ready = '0;
      checks++;
      if (fifo_full !== 4'b0000 || bank_req_valid !== 4'b0010) begin
         failures++;
         $display("FAIL fullpop_drop full=%b valid=%b exp=0000/0010",
                  fifo_full, bank_req_valid);
      end
      @(negedge clk);
      checks++;
      if (pe_req_ready !== 4'b0100) begin
         failures++;
         $display("FAIL fullpop_accept got=%b exp=0100", pe_req_ready);
      end
      tick();
      idle();
      checks++;
      if (fifo_full !== 4'b0010) begin
         failures++;
         $display("FAIL fullpop_refull got=%b exp=0010", fifo_full);
      end
      bank_req_ready = 4'b0010;
      for (int k = 0; k < FD; k++) begin
         checks++;
         if (bank_req_addr[1*AW +: AW] !== AW'(ea[k]) ||
             bank_req_tag[1*TW +: TW] !== TW'(et[k])) begin
            failures++;
            $display("FAIL fullpop_order k=%0d addr=%h tag=%0d exp=%h/%0d",
                     k, bank_req_addr[1*AW +: AW],
                     bank_req_tag[1*TW +: TW], ea[k], et[k]);
         end
         tick();
      end
      idle();
   endtask

   task automatic test_flush();
      do_reset();
      set_req(0, 8'h00);
      set_req(1, 8'h03);
      tick();
      tick();
      idle();
      checks++;
      if (bank_req_valid !== 4'b1001) begin
         failures++;
         $display("FAIL flush_pre got=%b exp=1001", bank_req_valid);
      end
      flush = 1'b1;
      set_req(2, 8'h01);
      bank_req_ready = '1;
      @(negedge clk);
      checks++;
      if (pe_req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL flush_ready got=%b exp=0000", pe_req_ready);
      end
      tick();
      idle();
      checks++;
      if (bank_req_valid !== 4'b0000 || fifo_full !== 4'b0000) begin
         failures++;
         $display("FAIL flush_clear valid=%b full=%b exp=0000/0000",
                  bank_req_valid, fifo_full);
      end
      set_req(0, 8'h07);
      set_req(2, 8'h0B);
      @(negedge clk);
      checks++;
      if (pe_req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL flush_rr got=%b exp=0001", pe_req_ready);
      end
      tick();
      idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_req(0, 8'h04);
      set_req(1, 8'h02);
      tick();
      pe_req_valid[1] = 1'b0;
      tick();
      idle();
      checks++;
      if (bank_req_valid !== 4'b0101) begin
         failures++;
         $display("FAIL rstmid_pre got=%b exp=0101", bank_req_valid);
      end
      reset = 1'b0;
      set_req(2, 8'h01);
      @(negedge clk);
      checks++;
      if (pe_req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL rstmid_ready got=%b exp=0000", pe_req_ready);
      end
      tick();
      checks++;
      if (bank_req_valid !== '0 || fifo_full !== '0 ||
          bank_req_addr !== '0 || bank_req_tag !== '0) begin
         failures++;
         $display("FAIL rstmid_outs v=%b f=%b a=%h t=%h exp=0",
                  bank_req_valid, fifo_full, bank_req_addr, bank_req_tag);
      end
      reset = 1'b1;
      idle();
      set_req(1, 8'h03);
      @(negedge clk);
      checks++;
      if (pe_req_ready !== 4'b0010) begin
         failures++;
         $display("FAIL rstmid_new_ready got=%b exp=0010", pe_req_ready);
      end
      tick();
      idle();
      checks++;
      if (bank_req_valid !== 4'b1000 ||
          bank_req_addr[3*AW +: AW] !== 6'h00 ||
          bank_req_tag[3*TW +: TW] !== 2'd1) begin
         failures++;
         $display("FAIL rstmid_new_out v=%b a=%h t=%0d exp=1000/00/1",
                  bank_req_valid, bank_req_addr[3*AW +: AW],
                  bank_req_tag[3*TW +: TW]);
      end
   endtask

   task automatic test_random();
      logic [NP-1:0] acc;
      logic [NP-1:0] exp_rdy;
      logic [7:0]    nidx;
      bit [7:0]      ent;
      bit            ev;
      int            win;
      int            best;
      int            d;
      int            bk;
      do_reset();
      for (int b = 0; b < NB; b++) begin
         mq[b].delete();
         rr[b] = 0;
      end
      acc = '0;
      for (int c = 0; c < 600; c++) begin
         for (int p = 0; p < NP; p++) begin
            if (!(pe_req_valid[p] && !acc[p])) begin
               pe_req_valid[p] = ($urandom_range(0, 3) != 0);
               nidx = 8'($urandom);
               if ($urandom_range(0, 1) == 1)
                  nidx[1:0] = 2'($urandom_range(0, 1));
               pe_req_idx[p*IW +: IW] = nidx;
            end
         end
         bank_req_ready = 4'($urandom);
         flush = ($urandom_range(0, 39) == 0);
         @(negedge clk);
         exp_rdy = '0;
         for (int b = 0; b < NB; b++) begin
            win = -1;
            best = NP;
            for (int p = 0; p < NP; p++) begin
               if (pe_req_valid[p] &&
                   pe_req_idx[p*IW +: BW] == BW'(b)) begin
                  d = (p - rr[b] + NP) % NP;
                  if (d < best) begin
                     best = d;
                     win = p;
                  end
               end
            end
            if (win >= 0 && mq[b].size() < FD && !flush)
               exp_rdy[win] = 1'b1;
         end
         checks++;
         if (pe_req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL rand_ready cyc=%0d got=%b exp=%b",
                     c, pe_req_ready, exp_rdy);
         end
         for (int b = 0; b < NB; b++) begin
            ev = (mq[b].size() != 0);
            checks++;
            if (bank_req_valid[b] !== ev ||
                fifo_full[b] !== (mq[b].size() == FD)) begin
               failures++;
               $display("FAIL rand_flags cyc=%0d b=%0d v=%b f=%b exp=%b/%b",
                        c, b, bank_req_valid[b], fifo_full[b], ev,
                        mq[b].size() == FD);
            end
            if (ev) begin
               ent = mq[b][0];
               checks++;
               if (bank_req_addr[b*AW +: AW] !== ent[5:0] ||
                   bank_req_tag[b*TW +: TW] !== ent[7:6]) begin
                  failures++;
                  $display("FAIL rand_head cyc=%0d b=%0d a=%h t=%0d exp=%h/%0d",
                           c, b, bank_req_addr[b*AW +: AW],
                           bank_req_tag[b*TW +: TW], ent[5:0], ent[7:6]);
               end
            end
         end
         acc = exp_rdy;
         @(posedge clk);
         if (flush) begin
            for (int b = 0; b < NB; b++) begin
               mq[b].delete();
               rr[b] = 0;
            end
         end else begin
            for (int b = 0; b < NB; b++) begin
               if (mq[b].size() != 0 && bank_req_ready[b])
                  ent = mq[b].pop_front();
            end
            for (int p = 0; p < NP; p++) begin
               if (exp_rdy[p]) begin
                  bk = int'(pe_req_idx[p*IW +: BW]);
                  mq[bk].push_back({TW'(p),
                                    pe_req_idx[p*IW+BW +: AW]});
                  rr[bk] = (p + 1) % NP;
               end
            end
         end
         #1;
      end
      idle();
   endtask

   initial begin
      idle();
      reset = 1'b0;
      test_reset();
      test_single();
      test_conflict();
      test_fairness();
      test_full_pop();
      test_flush();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
